// File: rtl/c_mac_pkg.sv
// c_mac_pkg: shared state enum, default widths and complex word type for the MAC sequencer
package c_mac_pkg;
  localparam int Q_DEF = 8;
  localparam int N_DEF = 16;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT, S_CLEAR, S_OUT} seq_state_t;
  typedef struct packed {
    logic signed [N_DEF-1:0] re;
    logic signed [N_DEF-1:0] im;
  } cplx_t;
endpackage

// File: rtl/c_dot_cnt.sv
// c_dot_cnt: loadable down-counter with a count-equals-one flag
module c_dot_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         one_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign one_o = cnt_q == W'(1);
endmodule

// File: rtl/c_dot_seq.sv
// c_dot_seq: feeds complex operand beats into c_mac, collects the accumulated result and clears it
module c_dot_seq
  import c_mac_pkg::*;
#(
  parameter int Q       = Q_DEF,
  parameter int N       = N_DEF,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [N-1:0]     op_ar,
  input  logic [N-1:0]     op_ai,
  input  logic [N-1:0]     op_br,
  input  logic [N-1:0]     op_bi,
  output logic             mac_en,
  output logic             mac_clear,
  output logic [N-1:0]     mac_ar,
  output logic [N-1:0]     mac_ai,
  output logic [N-1:0]     mac_br,
  output logic [N-1:0]     mac_bi,
  input  logic [N-1:0]     mac_r_in,
  input  logic [N-1:0]     mac_i_in,
  input  logic             mac_result_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_r,
  output logic [N-1:0]     res_i,
  output logic             res_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  if (Q < 0 || Q >= N || N != N_DEF) begin : g_bad_param
    $error("c_dot_seq: unsupported Q/N combination");
  end
  seq_state_t state_q, state_d;
  cplx_t a_q, a_d, b_q, b_d, res_q, res_d;
  logic mac_en_q, mac_clear_q, res_err_q, res_err_d;
  logic cmd_go, accept, done, beat_one, tmo_one;
  assign cmd_go = state_q == S_IDLE && start && len != '0;
  assign accept = state_q == S_RUN && op_valid;
  assign done   = state_q == S_WAIT && (mac_result_valid || tmo_one);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = cmd_go ? S_RUN : S_IDLE;
      S_RUN:   state_d = (accept && beat_one) ? S_WAIT : S_RUN;
      S_WAIT:  state_d = done ? S_CLEAR : S_WAIT;
      S_CLEAR: state_d = S_OUT;
      S_OUT:   state_d = res_ready ? S_IDLE : S_OUT;
      default: state_d = S_IDLE;
    endcase
    a_d       = accept ? cplx_t'{op_ar, op_ai} : a_q;
    b_d       = accept ? cplx_t'{op_br, op_bi} : b_q;
    res_d     = !done ? res_q : mac_result_valid ? cplx_t'{mac_r_in, mac_i_in} : '0;
    res_err_d = done ? !mac_result_valid : res_err_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      res_err_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      res_err_q   <= res_err_d;
      mac_en_q    <= accept;
      mac_clear_q <= done;
    end
  c_dot_cnt #(.W(LEN_W)) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(cmd_go),
    .val_i (len),
    .dec_i (accept),
    .one_o (beat_one)
  );
  c_dot_cnt #(.W(TW)) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(accept && beat_one),
    .val_i (TW'(TIMEOUT)),
    .dec_i (state_q == S_WAIT),
    .one_o (tmo_one)
  );
  assign busy      = state_q != S_IDLE;
  assign op_ready  = state_q == S_RUN;
  assign res_valid = state_q == S_OUT;
  assign mac_en    = mac_en_q;
  assign mac_clear = mac_clear_q;
  assign mac_ar    = a_q.re;
  assign mac_ai    = a_q.im;
  assign mac_br    = b_q.re;
  assign mac_bi    = b_q.im;
  assign res_r     = res_q.re;
  assign res_i     = res_q.im;
  assign res_err   = res_err_q;
endmodule

// File: tb/tb_c_dot_seq.sv
// tb_c_dot_seq: scoreboard bench for the c_dot_seq operand sequencer and result collector
module tb_c_dot_seq;
  typedef struct packed {logic [15:0] ar, ai, br, bi;} beat_t;
  typedef struct packed {logic [15:0] r, i; logic err;} res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] len = '0;
  logic busy, op_ready, mac_en, mac_clear, res_valid, res_err;
  logic op_valid = 1'b0;
  logic [15:0] op_ar = '0, op_ai = '0, op_br = '0, op_bi = '0;
  logic [15:0] mac_ar, mac_ai, mac_br, mac_bi, res_r, res_i;
  logic [15:0] mac_r_in = '0, mac_i_in = '0;
  logic mac_result_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [101:0] all_out;
  beat_t stim[$], exp_beats[$];
  res_t exp_res[$];
  beat_t mb;
  res_t mr;
  int checks = 0, failures = 0, en_cnt = 0, clr_cnt = 0;
  logic signed [31:0] acc_r, acc_i;
  always #5 clk = ~clk;
  c_dot_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_ar(op_ar), .op_ai(op_ai), .op_br(op_br), .op_bi(op_bi),
    .mac_en(mac_en), .mac_clear(mac_clear),
    .mac_ar(mac_ar), .mac_ai(mac_ai), .mac_br(mac_br), .mac_bi(mac_bi),
    .mac_r_in(mac_r_in), .mac_i_in(mac_i_in), .mac_result_valid(mac_result_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_r(res_r), .res_i(res_i), .res_err(res_err)
  );
  assign all_out = {busy, op_ready, mac_en, mac_clear, mac_ar, mac_ai, mac_br, mac_bi,
                    res_valid, res_r, res_i, res_err};
  always @(negedge clk) begin
    #1;
    if (mac_en === 1'b1) begin
      en_cnt++;
      checks++;
      if (exp_beats.size() == 0) begin
        failures++;
        $display("FAIL mac_beat got=%h required=none", {mac_ar, mac_ai, mac_br, mac_bi});
      end else begin
        mb = exp_beats.pop_front();
        if ({mac_ar, mac_ai, mac_br, mac_bi} !== mb) begin
          failures++;
          $display("FAIL mac_beat got=%h required=%h", {mac_ar, mac_ai, mac_br, mac_bi}, mb);
        end
      end
    end
    if (mac_clear === 1'b1) clr_cnt++;
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      checks++;
      if (exp_res.size() == 0) begin
        failures++;
        $display("FAIL result got=%h required=none", {res_r, res_i, res_err});
      end else begin
        mr = exp_res.pop_front();
        if ({res_r, res_i, res_err} !== mr) begin
          failures++;
          $display("FAIL result got=%h required=%h", {res_r, res_i, res_err}, mr);
        end
      end
    end
  end
  task automatic gen_stim(input int n);
    repeat (n) stim.push_back({16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
  endtask
  task automatic start_cmd(input int n);
    acc_r = 0;
    acc_i = 0;
    start = 1'b1;
    len = 8'(n);
    @(negedge clk);
    start = 1'b0;
    len = '0;
  endtask
  task automatic feed(input int n, input logic [7:0] pat, input int plen);
    int sent = 0;
    int c = 0;
    beat_t b;
    while (sent < n && c < 200) begin
      b = stim.size() != 0 ? stim[0] : '0;
      op_valid = pat[c % plen];
      {op_ar, op_ai, op_br, op_bi} = op_valid ? b : {$urandom, $urandom};
      if (op_valid && op_ready === 1'b1) begin
        exp_beats.push_back(b);
        void'(stim.pop_front());
        acc_r += ($signed(b.ar) * $signed(b.br) - $signed(b.ai) * $signed(b.bi)) >>> 8;
        acc_i += ($signed(b.ar) * $signed(b.bi) + $signed(b.ai) * $signed(b.br)) >>> 8;
        sent++;
      end
      c++;
      @(negedge clk);
    end
    op_valid = 1'b0;
    checks++;
    if (sent != n) begin
      failures++;
      $display("FAIL feed_beats got=%0d required=%0d", sent, n);
    end
  endtask
  task automatic mac_respond(input logic [15:0] r, input logic [15:0] i);
    exp_res.push_back({r, i, 1'b0});
    mac_result_valid = 1'b1;
    mac_r_in = r;
    mac_i_in = i;
    @(negedge clk);
    mac_result_valid = 1'b0;
    {mac_r_in, mac_i_in} = $urandom;
  endtask
  task automatic handshake;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h required=0", all_out); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy got=%b required=0", busy); end
  endtask
  task automatic test_single;
    int e0 = en_cnt, c0 = clr_cnt;
    stim.push_back({16'h0100, 16'h0200, 16'h0300, 16'h0400});
    start_cmd(1);
    checks++;
    if ({busy, op_ready} !== 2'b11) begin failures++; $display("FAIL single_run busy/op_ready got=%b required=11", {busy, op_ready}); end
    feed(1, 8'h01, 1);
    checks++;
    if ({mac_en, op_ready} !== 2'b10) begin failures++; $display("FAIL single_wait mac_en/op_ready got=%b required=10", {mac_en, op_ready}); end
    mac_respond(16'hFB00, 16'h0A00);
    checks++;
    if ({mac_en, mac_clear, res_valid} !== 3'b010) begin failures++; $display("FAIL single_clear en/clear/valid got=%b required=010", {mac_en, mac_clear, res_valid}); end
    @(negedge clk);
    checks++;
    if ({res_valid, res_err, mac_clear} !== 3'b100) begin failures++; $display("FAIL single_out valid/err/clear got=%b required=100", {res_valid, res_err, mac_clear}); end
    handshake;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_idle busy got=%b required=0", busy); end
    @(negedge clk);
    checks++;
    if (en_cnt - e0 != 1 || clr_cnt - c0 != 1) begin failures++; $display("FAIL single_pulses en=%0d clear=%0d required=1/1", en_cnt - e0, clr_cnt - c0); end
  endtask
  task automatic test_gapped;
    int e0 = en_cnt;
    gen_stim(4);
    start_cmd(4);
    feed(4, 8'b0010_1101, 6);
    checks++;
    if ({op_ready, busy} !== 2'b01) begin failures++; $display("FAIL gapped_wait op_ready/busy got=%b required=01", {op_ready, busy}); end
    mac_respond(acc_r[15:0], acc_i[15:0]);
    @(negedge clk);
    handshake;
    @(negedge clk);
    checks++;
    if (en_cnt - e0 != 4) begin failures++; $display("FAIL gapped_beats got=%0d required=4", en_cnt - e0); end
  endtask
  task automatic test_timeout;
    int c0 = clr_cnt;
    gen_stim(2);
    start_cmd(2);
    feed(2, 8'h01, 1);
    exp_res.push_back({16'h0, 16'h0, 1'b1});
    repeat (63) @(negedge clk);
    checks++;
    if ({busy, op_ready, mac_clear, res_valid} !== 4'b1000) begin failures++; $display("FAIL timeout_wait64 got=%b required=1000", {busy, op_ready, mac_clear, res_valid}); end
    @(negedge clk);
    checks++;
    if (mac_clear !== 1'b1) begin failures++; $display("FAIL timeout_clear got=%b required=1", mac_clear); end
    @(negedge clk);
    checks++;
    if ({res_valid, res_err, res_r, res_i} !== {2'b11, 32'h0}) begin failures++; $display("FAIL timeout_out got=%h required=%h", {res_valid, res_err, res_r, res_i}, {2'b11, 32'h0}); end
    handshake;
    @(negedge clk);
    checks++;
    if (clr_cnt - c0 != 1) begin failures++; $display("FAIL timeout_clears got=%0d required=1", clr_cnt - c0); end
  endtask
  task automatic test_timeout_tie;
    gen_stim(1);
    start_cmd(1);
    feed(1, 8'h01, 1);
    repeat (63) @(negedge clk);
    mac_respond(16'h1234, 16'hABCD);
    checks++;
    if (mac_clear !== 1'b1) begin failures++; $display("FAIL tie_clear got=%b required=1", mac_clear); end
    @(negedge clk);
    checks++;
    if ({res_valid, res_err} !== 2'b10) begin failures++; $display("FAIL tie_err valid/err got=%b required=10", {res_valid, res_err}); end
    handshake;
  endtask
  task automatic test_hold;
    int e0 = en_cnt;
    gen_stim(3);
    start_cmd(3);
    feed(3, 8'h01, 1);
    mac_respond(acc_r[15:0], acc_i[15:0]);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      start = k == 3;
      len = 8'd3;
      checks++;
      if ({res_valid, busy, res_r, res_i, res_err} !== {2'b11, acc_r[15:0], acc_i[15:0], 1'b0}) begin
        failures++;
        $display("FAIL hold_cycle%0d got=%h required=%h", k, {res_valid, busy, res_r, res_i, res_err}, {2'b11, acc_r[15:0], acc_i[15:0], 1'b0});
      end
      @(negedge clk);
    end
    start = 1'b0;
    len = '0;
    handshake;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL hold_release busy got=%b required=0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || en_cnt - e0 != 3) begin failures++; $display("FAIL hold_no_restart busy=%b beats=%0d required=0/3", busy, en_cnt - e0); end
  endtask
  task automatic test_ignored;
    int e0 = en_cnt;
    start = 1'b1;
    len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL len0_ignored busy got=%b required=0", busy); end
    mac_result_valid = 1'b1;
    @(negedge clk);
    mac_result_valid = 1'b0;
    checks++;
    if ({busy, res_valid} !== 2'b00) begin failures++; $display("FAIL stray_result_idle got=%b required=00", {busy, res_valid}); end
    gen_stim(3);
    start_cmd(3);
    start = 1'b1;
    len = 8'd7;
    mac_result_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len = '0;
    mac_result_valid = 1'b0;
    checks++;
    if ({op_ready, mac_en} !== 2'b10) begin failures++; $display("FAIL run_ignores got=%b required=10", {op_ready, mac_en}); end
    feed(3, 8'h01, 1);
    checks++;
    if (op_ready !== 1'b0) begin failures++; $display("FAIL run_no_reload op_ready got=%b required=0", op_ready); end
    mac_respond(acc_r[15:0], acc_i[15:0]);
    @(negedge clk);
    handshake;
    @(negedge clk);
    checks++;
    if (en_cnt - e0 != 3) begin failures++; $display("FAIL ignored_beats got=%0d required=3", en_cnt - e0); end
  endtask
  task automatic test_reset_mid;
    int c0 = clr_cnt;
    gen_stim(5);
    start_cmd(5);
    feed(2, 8'h01, 1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL midreset_outputs got=%h required=0", all_out); end
    stim.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL midreset_idle got=%h required=0", all_out); end
    gen_stim(2);
    start_cmd(2);
    feed(2, 8'h01, 1);
    mac_respond(acc_r[15:0], acc_i[15:0]);
    @(negedge clk);
    checks++;
    if ({res_valid, res_err} !== 2'b10) begin failures++; $display("FAIL midreset_out got=%b required=10", {res_valid, res_err}); end
    handshake;
    @(negedge clk);
    checks++;
    if (clr_cnt - c0 != 1) begin failures++; $display("FAIL midreset_clears got=%0d required=1", clr_cnt - c0); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_single;
    test_gapped;
    test_timeout;
    test_timeout_tie;
    test_hold;
    test_ignored;
    test_reset_mid;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_res.size() != 0 || exp_beats.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain results=%0d beats=%0d required=0/0", exp_res.size(), exp_beats.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/c_dot_seq.md
# c_dot_seq

Operand sequencer and result collector for the complex MAC (`c_mac`). It accepts a dot-product command of `len` beats and takes complex operand pairs from an upstream valid/ready stream. It drives them one per cycle into the MAC's `mac_en`/`in_*` interface, waits for `mac_result_valid`, captures the accumulated result and issues `mac_clear`. The result is then presented downstream on a valid/ready port.

## Interface
Parameters:
- `Q`, 8: fractional bits of the QN.Q operands (pass-through; no arithmetic here).
- `N`, 16: operand and result word width.
- `LEN_W`, 8: width of the beat-count field.
- `TIMEOUT`, 64: maximum cycles in WAIT before an error result is forced.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  command strobe, sampled in IDLE only.
- `len`  in  LEN_W  number of operand beats; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `op_valid`  in  1  upstream operand beat valid.
- `op_ready`  out  1  high in RUN only.
- `op_ar`, `op_ai`, `op_br`, `op_bi`  in  N each  signed operand beat (a = ar + j·ai, b = br + j·bi).
- `mac_en`  out  1  registered one-cycle beat strobe to the MAC.
- `mac_clear`  out  1  registered one-cycle accumulator clear.
- `mac_ar`, `mac_ai`, `mac_br`, `mac_bi`  out  N each  registered operands to the MAC `in_*`.
- `mac_r_in`, `mac_i_in`  in  N each  MAC accumulator outputs.
- `mac_result_valid`  in  1  MAC result strobe.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_r`, `res_i`  out  N each  captured result.
- `res_err`  out  1  result was forced by timeout; qualified by `res_valid`.

## Operation
- States: IDLE, RUN, WAIT, CLEAR, OUT.
- IDLE -> RUN: `start && len != 0`. Load the beat counter with `len`.
  - `start` with `len == 0` is ignored.
  - `start` in any non-IDLE state is ignored.
- RUN: a beat is accepted when `op_valid && op_ready`.
  - Each accepted beat registers the operands into `mac_*` and pulses `mac_en` on the next cycle.
  - The counter decrements per accepted beat.
  - The last accepted beat (counter == 1) moves to WAIT.
  - Cycles without `op_valid` produce no `mac_en`; operand registers hold their value.
- WAIT: on `mac_result_valid`, capture `mac_r_in`/`mac_i_in` into `res_r`/`res_i`, set `res_err = 0`, go to CLEAR.
  - After TIMEOUT cycles without `mac_result_valid`: `res_r = res_i = 0`, `res_err = 1`, go to CLEAR.
- CLEAR: `mac_clear = 1` for exactly one cycle, then OUT.
- OUT: `res_valid = 1`, with `res_*` stable until `res_ready`. The handshake cycle returns to IDLE.
- `mac_result_valid` outside WAIT is ignored, with no state change.
- No arithmetic is performed; operand and result words pass through bit-exact. Q format is the MAC's concern.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE; all outputs 0, including `mac_*` operands, `res_*`, `busy`, `op_ready`, `mac_en` and `mac_clear`. Counters are cleared.
- Reset mid-operation aborts immediately: no `mac_clear` is issued and no result is produced.
- `op_ready` is combinational from the state register only, with no dependence on `op_valid`.
- Accept at edge k gives `mac_en` high and operands valid during cycle k+1.
- Back-to-back beats are allowed: one beat per cycle sustained.
- `len` beats with continuous `op_valid`: RUN lasts `len` cycles, and the last `mac_en` falls in the first WAIT cycle.
- Result capture at edge m gives `mac_clear` high in cycle m+1 and `res_valid` high from m+2.
- Minimum command turnaround: `start` accepted one cycle after the OUT handshake (first IDLE cycle).
- The timeout counter starts at WAIT entry and counts inclusively: error at the TIMEOUT-th WAIT cycle.
- `mac_result_valid` arriving in the same cycle as the timeout expiry: the valid result wins, with `res_err = 0`.

## Structure
- A shared package `c_mac_pkg` holds the state enum `seq_state_t`, default Q/N constants, and a `cplx_t` struct (signed re/im of N bits) used for the operand and result bundles.
- One natural sub-module: `c_dot_cnt`, a loadable down-counter with a zero/one flag, instantiated twice (beat counter and timeout counter).
- Everything else is a single FSM plus the registered output stage.

## Test plan
- `len = 1`, beat a = 0x0100 + j0x0200, b = 0x0300 + j0x0400; the MAC model returns 0xFB00 + j0x0A00.
  - Expect `mac_en` for exactly one cycle with those operands, then `res` = 0xFB00/0x0A00, `res_err = 0`, and one `mac_clear` pulse.
- `len = 4` with `op_valid` gapped (1,0,1,1,0,1): exactly 4 `mac_en` pulses, operands in order, and `op_ready` falls after the 4th accept.
- MAC model never asserts valid, `TIMEOUT = 64`: `res_valid` with `res_err = 1` and `res` = 0/0 at WAIT cycle 64, and `mac_clear` still pulses.
- `res_ready` held low for 10 cycles in OUT: `res_*` stable, a new `start` is ignored, `busy` stays high, and the FSM returns to IDLE on the handshake.
- `start` with `len = 0`, and `start` pulsed during RUN: no state change and no extra beats.
- `rst_n` low in the middle of RUN (after 2 of 5 beats): all outputs 0 asynchronously. A new `len = 2` command afterwards completes normally.
